backward_riccati_step_seq: RTL and testbench

Computes one backward-pass step of the MPC horizon: feedforward term d_k = Quu_inv·(Bᵀ·p_next + r_k) and cost-to-go p_k = q_k + AmBKt·p_next − Kinfᵀ·r_k, using a single time-multiplexed signed MAC. It sits directly upstream of forward_primal_update_seq, which consumes d_k together with the same Kinf, A_mat and B_mat. Control uses a start/done handshake. Results hold until the next start.

---
 rtl/mpc_pkg.sv | 40 ++++
 rtl/mpc_mac.sv | 48 ++++
 rtl/backward_riccati_step_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_backward_riccati_step_seq.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpc_pkg.sv
// Shared definitions for the MPC solver datapath blocks.
//   - bwd_state_e : state encoding of the backward Riccati step sequencer
//   - acc_width   : accumulator width that cannot overflow for n products of w-bit words
//   - narrow_word : narrowing of a wide signed value to w bits
// Build option: define BACKWARD_SAT_EN to make narrow_word saturate; otherwise it wraps
// (keeps the low w bits, two's complement).
package mpc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StBtp,
    StDff,
    StPcg,
    StFin
  } bwd_state_e;

  // Sum of n products of two w-bit words plus one pre-shifted additive term, with margin.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned n);
    return 2 * w + $clog2(n) + 1;
  endfunction

  // Result is sign-extended to 64 bits; callers keep the low w bits.
  function automatic logic signed [63:0] narrow_word(input logic signed [63:0] v,
                                                     input int unsigned w);
`ifdef BACKWARD_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    logic signed [63:0] tmp;
    tmp = v <<< (64 - w);
    return tmp >>> (64 - w);
`endif
  endfunction

endpackage

// File: rtl/mpc_mac.sv
// Signed multiply-accumulate unit shared by all phases of the backward step.
// Ports:
//   clk, rst_n : clock, active-low async reset (already synchronised by the parent)
//   en         : accumulate sum into the accumulator this cycle
//   clr        : clear the accumulator (takes priority over en)
//   sub        : subtract the product instead of adding it
//   add_en     : also add addend, pre-shifted left by FRAC
//   a, b       : signed W-bit multiplier operands
//   addend     : signed W-bit additive term
//   sum        : combinational acc +/- a*b (+ addend<<FRAC), the value written on en
module mpc_mac #(
  parameter int unsigned W    = 16,
  parameter int unsigned FRAC = 0,
  parameter int unsigned AW   = 37
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          sub,
  input  logic          add_en,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  addend,
  output logic [AW-1:0] sum
);

  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  prod_ext;
  logic signed [AW-1:0]  add_ext;
  logic signed [AW-1:0]  acc_q;

  assign prod     = $signed(a) * $signed(b);
  assign prod_ext = AW'(prod);
  assign add_ext  = add_en ? (AW'($signed(addend)) <<< FRAC) : {AW{1'b0}};
  assign sum      = acc_q + (sub ? -prod_ext : prod_ext) + add_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/backward_riccati_step_seq.sv
// One backward-pass step of the MPC horizon on a single time-multiplexed MAC:
//   t   = r_k + B_mat^T * p_next           (BTP phase, kept internally)
//   d_k = Quu_inv * t                      (DFF phase)
//   p_k = q_k + AmBKt * p_next - Kinf^T*r_k (PCG phase)
// Each result row is shifted right by FRAC and narrowed to W bits at row end.
// Build option: BACKWARD_SAT_EN selects saturating narrowing (default wraps).
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   start      : begin a step (only honoured in idle)
//   p_next, r_k, q_k, B_mat, Kinf, Quu_inv, AmBKt : flattened W-bit operands,
//                element [i][j] of an R x K matrix sits at bits (i*K+j)*W +: W
//   d_k, p_k   : results, updated row by row, valid at done
//   done       : one-cycle pulse at the end of a step
module backward_riccati_step_seq
  import mpc_pkg::*;
#(
  parameter int unsigned STATE_DIM   = 12,
  parameter int unsigned CONTROL_DIM = 4,
  parameter int unsigned W           = 16,
  parameter int unsigned FRAC        = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [STATE_DIM*W-1:0]                p_next,
  input  logic [CONTROL_DIM*W-1:0]              r_k,
  input  logic [STATE_DIM*W-1:0]                q_k,
  input  logic [STATE_DIM*CONTROL_DIM*W-1:0]    B_mat,
  input  logic [CONTROL_DIM*STATE_DIM*W-1:0]    Kinf,
  input  logic [CONTROL_DIM*CONTROL_DIM*W-1:0]  Quu_inv,
  input  logic [STATE_DIM*STATE_DIM*W-1:0]      AmBKt,
  output logic [CONTROL_DIM*W-1:0]              d_k,
  output logic [STATE_DIM*W-1:0]                p_k,
  output logic                                  done
);

  localparam int unsigned AccW = acc_width(W, STATE_DIM + CONTROL_DIM);
  localparam int unsigned IdxW = $clog2(STATE_DIM + CONTROL_DIM + 1);

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  bwd_state_e state_q, state_d, nxt_phase;
  logic [IdxW-1:0] row_q, row_d, col_q, col_d;
  logic            done_q, done_d;
  logic [W-1:0]    t_q [CONTROL_DIM];
  logic [CONTROL_DIM*W-1:0] d_q;
  logic [STATE_DIM*W-1:0]   p_q;

  logic         mac_en, mac_clr, mac_sub, mac_add;
  logic         row_end, last_row;
  logic [W-1:0] op_a, op_b, addend;
  logic signed [AccW-1:0] mac_sum, shifted;
  logic [W-1:0] nar;

  mpc_mac #(
    .W    (W),
    .FRAC (FRAC),
    .AW   (AccW)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (mac_en),
    .clr    (mac_clr),
    .sub    (mac_sub),
    .add_en (mac_add),
    .a      (op_a),
    .b      (op_b),
    .addend (addend),
    .sum    (mac_sum)
  );

  assign shifted = mac_sum >>> FRAC;
  assign nar     = W'(narrow_word(64'(shifted), W));

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    done_d    = 1'b0;
    nxt_phase = StIdle;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    mac_sub   = 1'b0;
    mac_add   = 1'b0;
    row_end   = 1'b0;
    last_row  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    addend    = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mac_clr = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = StBtp;
        end
      end
      StBtp: begin
        mac_en    = 1'b1;
        row_end   = (col_q == IdxW'(STATE_DIM - 1));
        last_row  = (row_q == IdxW'(CONTROL_DIM - 1));
        nxt_phase = StDff;
        mac_add   = row_end;
        for (int j = 0; j < STATE_DIM; j++) begin
          if (col_q == IdxW'(j)) op_b = p_next[j*W +: W];
          for (int i = 0; i < CONTROL_DIM; i++) begin
            if (col_q == IdxW'(j) && row_q == IdxW'(i)) begin
              op_a = B_mat[(j*CONTROL_DIM + i)*W +: W];
            end
          end
        end
        for (int i = 0; i < CONTROL_DIM; i++) begin
          if (row_q == IdxW'(i)) addend = r_k[i*W +: W];
        end
      end
      StDff: begin
        mac_en    = 1'b1;
        row_end   = (col_q == IdxW'(CONTROL_DIM - 1));
        last_row  = (row_q == IdxW'(CONTROL_DIM - 1));
        nxt_phase = StPcg;
        for (int j = 0; j < CONTROL_DIM; j++) begin
          if (col_q == IdxW'(j)) op_b = t_q[j];
          for (int i = 0; i < CONTROL_DIM; i++) begin
            if (col_q == IdxW'(j) && row_q == IdxW'(i)) begin
              op_a = Quu_inv[(i*CONTROL_DIM + j)*W +: W];
            end
          end
        end
      end
      StPcg: begin
        mac_en    = 1'b1;
        row_end   = (col_q == IdxW'(STATE_DIM + CONTROL_DIM - 1));
        last_row  = (row_q == IdxW'(STATE_DIM - 1));
        nxt_phase = StFin;
        mac_add   = row_end;
        // Columns 0..S-1 walk AmBKt*p_next, columns S..S+C-1 subtract Kinf^T*r_k.
        for (int j = 0; j < STATE_DIM; j++) begin
          if (col_q == IdxW'(j)) op_b = p_next[j*W +: W];
          for (int i = 0; i < STATE_DIM; i++) begin
            if (col_q == IdxW'(j) && row_q == IdxW'(i)) begin
              op_a = AmBKt[(i*STATE_DIM + j)*W +: W];
            end
          end
        end
        for (int j = 0; j < CONTROL_DIM; j++) begin
          if (col_q == IdxW'(STATE_DIM + j)) begin
            op_b    = r_k[j*W +: W];
            mac_sub = 1'b1;
          end
          for (int i = 0; i < STATE_DIM; i++) begin
            if (col_q == IdxW'(STATE_DIM + j) && row_q == IdxW'(i)) begin
              op_a = Kinf[(j*STATE_DIM + i)*W +: W];
            end
          end
        end
        for (int i = 0; i < STATE_DIM; i++) begin
          if (row_q == IdxW'(i)) addend = q_k[i*W +: W];
        end
      end
      StFin: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (mac_en) begin
      if (row_end) begin
        mac_clr = 1'b1;
        col_d   = '0;
        if (last_row) begin
          row_d   = '0;
          state_d = nxt_phase;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
      d_q     <= '0;
      p_q     <= '0;
      for (int i = 0; i < CONTROL_DIM; i++) t_q[i] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
      if (mac_en && row_end) begin
        if (state_q == StBtp) begin
          for (int i = 0; i < CONTROL_DIM; i++) begin
            if (row_q == IdxW'(i)) t_q[i] <= nar;
          end
        end else if (state_q == StDff) begin
          for (int i = 0; i < CONTROL_DIM; i++) begin
            if (row_q == IdxW'(i)) d_q[i*W +: W] <= nar;
          end
        end else begin
          for (int i = 0; i < STATE_DIM; i++) begin
            if (row_q == IdxW'(i)) p_q[i*W +: W] <= nar;
          end
        end
      end
    end
  end

  assign d_k  = d_q;
  assign p_k  = p_q;
  assign done = done_q;

endmodule

// File: tb/tb_backward_riccati_step_seq.sv
// Bench for backward_riccati_step_seq: two instances (FRAC=0 and FRAC=8) share the
// stimulus; a matrix-arithmetic reference model gives the expected d_k/p_k at done.
module tb_backward_riccati_step_seq;

  localparam int S = 12;
  localparam int C = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;

  logic signed [15:0] pn [S];
  logic signed [15:0] rk [C];
  logic signed [15:0] qk [S];
  logic signed [15:0] bm [S][C];
  logic signed [15:0] kf [C][S];
  logic signed [15:0] qi [C][C];
  logic signed [15:0] am [S][S];

  logic [S*W-1:0]   p_next, q_k;
  logic [C*W-1:0]   r_k;
  logic [S*C*W-1:0] B_mat;
  logic [C*S*W-1:0] Kinf;
  logic [C*C*W-1:0] Quu_inv;
  logic [S*S*W-1:0] AmBKt;

  logic [C*W-1:0] d0, d8;
  logic [S*W-1:0] p0, p8;
  logic           done0, done8;

  always_comb begin
    for (int i = 0; i < S; i++) begin
      p_next[i*W +: W] = pn[i];
      q_k[i*W +: W]    = qk[i];
      for (int j = 0; j < C; j++) B_mat[(i*C + j)*W +: W] = bm[i][j];
      for (int j = 0; j < S; j++) AmBKt[(i*S + j)*W +: W] = am[i][j];
    end
    for (int i = 0; i < C; i++) begin
      r_k[i*W +: W] = rk[i];
      for (int j = 0; j < S; j++) Kinf[(i*S + j)*W +: W] = kf[i][j];
      for (int j = 0; j < C; j++) Quu_inv[(i*C + j)*W +: W] = qi[i][j];
    end
  end

  backward_riccati_step_seq #(.STATE_DIM(S), .CONTROL_DIM(C), .W(W), .FRAC(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .p_next(p_next), .r_k(r_k), .q_k(q_k),
    .B_mat(B_mat), .Kinf(Kinf), .Quu_inv(Quu_inv), .AmBKt(AmBKt),
    .d_k(d0), .p_k(p0), .done(done0)
  );

  backward_riccati_step_seq #(.STATE_DIM(S), .CONTROL_DIM(C), .W(W), .FRAC(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .p_next(p_next), .r_k(r_k), .q_k(q_k),
    .B_mat(B_mat), .Kinf(Kinf), .Quu_inv(Quu_inv), .AmBKt(AmBKt),
    .d_k(d8), .p_k(p8), .done(done8)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic signed [15:0] exp_d [2][C];
  logic signed [15:0] exp_p [2][S];

  function automatic longint fit(input longint v);
`ifdef BACKWARD_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    return longint'(shortint'(v));
`endif
  endfunction

  function automatic longint dget(input logic [C*W-1:0] v, input int i);
    return longint'($signed(v[i*W +: W]));
  endfunction

  function automatic longint pget(input logic [S*W-1:0] v, input int i);
    return longint'($signed(v[i*W +: W]));
  endfunction

  // Straight matrix arithmetic for both FRAC settings.
  task automatic model();
    longint acc;
    longint t [C];
    int sh;
    for (int f = 0; f < 2; f++) begin
      sh = (f == 0) ? 0 : 8;
      for (int i = 0; i < C; i++) begin
        acc = longint'(rk[i]) <<< sh;
        for (int j = 0; j < S; j++) acc += longint'(bm[j][i]) * longint'(pn[j]);
        t[i] = fit(acc >>> sh);
      end
      for (int i = 0; i < C; i++) begin
        acc = 0;
        for (int j = 0; j < C; j++) acc += longint'(qi[i][j]) * t[j];
        exp_d[f][i] = 16'(fit(acc >>> sh));
      end
      for (int i = 0; i < S; i++) begin
        acc = longint'(qk[i]) <<< sh;
        for (int j = 0; j < S; j++) acc += longint'(am[i][j]) * longint'(pn[j]);
        for (int j = 0; j < C; j++) acc -= longint'(kf[j][i]) * longint'(rk[j]);
        exp_p[f][i] = 16'(fit(acc >>> sh));
      end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (done0 || done8) begin
        done_cnt++;
        chk("done8 aligned with done0", longint'(done8), longint'(done0));
        for (int i = 0; i < C; i++) begin
          chk($sformatf("d_k[%0d] frac0", i), dget(d0, i), exp_d[0][i]);
          chk($sformatf("d_k[%0d] frac8", i), dget(d8, i), exp_d[1][i]);
        end
        for (int i = 0; i < S; i++) begin
          chk($sformatf("p_k[%0d] frac0", i), pget(p0, i), exp_p[0][i]);
          chk($sformatf("p_k[%0d] frac8", i), pget(p8, i), exp_p[1][i]);
        end
      end
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < S; i++) begin
      pn[i] = 0; qk[i] = 0;
      for (int j = 0; j < C; j++) bm[i][j] = 0;
      for (int j = 0; j < S; j++) am[i][j] = 0;
    end
    for (int i = 0; i < C; i++) begin
      rk[i] = 0;
      for (int j = 0; j < S; j++) kf[i][j] = 0;
      for (int j = 0; j < C; j++) qi[i][j] = 0;
    end
  endtask

  task automatic scen1();
    clear_all();
    for (int i = 0; i < C; i++) begin
      qi[i][i] = 1; bm[i][i] = 1; rk[i] = 16'(i + 1);
    end
    for (int i = 0; i < S; i++) begin
      pn[i] = 16'(i + 1); qk[i] = 16'(i + 1);
    end
  endtask

  function automatic logic signed [15:0] rnd(input int span);
    if (span == 0) return 16'($urandom);
    return 16'(int'($urandom_range(0, 2 * span)) - span);
  endfunction

  task automatic randomize_all(input int span);
    for (int i = 0; i < S; i++) begin
      pn[i] = rnd(span); qk[i] = rnd(span);
      for (int j = 0; j < C; j++) bm[i][j] = rnd(span);
      for (int j = 0; j < S; j++) am[i][j] = rnd(span);
    end
    for (int i = 0; i < C; i++) begin
      rk[i] = rnd(span);
      for (int j = 0; j < S; j++) kf[i][j] = rnd(span);
      for (int j = 0; j < C; j++) qi[i][j] = rnd(span);
    end
  endtask

  // Starts a step, measures start-to-done latency, returns just after the done cycle.
  task automatic run(input bit extra_starts);
    int lat;
    model();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      start = extra_starts && (k == 5 || k == 100);
      if (done0) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    chk("latency start to done", lat, 257);
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < C; i++) begin
      chk({tag, " d_k frac0"}, dget(d0, i), 0);
      chk({tag, " d_k frac8"}, dget(d8, i), 0);
    end
    for (int i = 0; i < S; i++) begin
      chk({tag, " p_k frac0"}, pget(p0, i), 0);
      chk({tag, " p_k frac8"}, pget(p8, i), 0);
    end
  endtask

  task automatic check_scen1_literals(input string tag);
    for (int i = 0; i < C; i++) chk({tag, " d_k literal"}, dget(d0, i), 2 * (i + 1));
    for (int i = 0; i < S; i++) chk({tag, " p_k literal"}, pget(p0, i), i + 1);
  endtask

  initial begin
    int dc;
    longint ov_exp;
    fork
      monitor();
    join_none

    clear_all();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    chk("done low in reset", longint'(done0), 0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Identity feedforward, plus an immediate back-to-back repeat.
    scen1();
    dc = done_cnt;
    run(1'b0);
    check_scen1_literals("scen1");
    run(1'b0);
    check_scen1_literals("scen1 back-to-back");
    repeat (5) @(posedge clk);
    #1;
    chk("done pulses for two runs", done_cnt - dc, 2);

    // Cost-to-go via AmBKt = I and Kinf all ones.
    clear_all();
    for (int i = 0; i < S; i++) begin
      am[i][i] = 1; pn[i] = 16'(i + 1);
    end
    for (int i = 0; i < C; i++) begin
      rk[i] = 16'(i + 1);
      for (int j = 0; j < S; j++) kf[i][j] = 1;
    end
    run(1'b0);
    for (int i = 0; i < S; i++) chk("scen2 p_k literal", pget(p0, i), i + 1 - 10);
    for (int i = 0; i < C; i++) chk("scen2 d_k literal", dget(d0, i), 0);

    // Narrowing at W on overflow.
    clear_all();
    for (int i = 0; i < C; i++) begin
      qi[i][i] = 1; bm[i][i] = 1;
    end
    pn[0] = 16'sd32767;
    rk[0] = 1;
`ifdef BACKWARD_SAT_EN
    ov_exp = 32767;
`else
    ov_exp = -32768;
`endif
    run(1'b0);
    chk("overflow d_k[0]", dget(d0, 0), ov_exp);

    // Fixed-point scaling with FRAC = 8.
    clear_all();
    for (int i = 0; i < C; i++) begin
      qi[i][i] = 256; bm[i][i] = 1;
    end
    rk[0] = 256; rk[1] = -512; rk[2] = 768; rk[3] = 0;
    run(1'b0);
    chk("frac8 d_k[0]", dget(d8, 0), 256);
    chk("frac8 d_k[1]", dget(d8, 1), -512);
    chk("frac8 d_k[2]", dget(d8, 2), 768);
    chk("frac8 d_k[3]", dget(d8, 3), 0);

    // Starts during a run must be ignored.
    scen1();
    dc = done_cnt;
    run(1'b1);
    repeat (300) @(posedge clk);
    #1;
    chk("single done with extra starts", done_cnt - dc, 1);
    check_scen1_literals("scen1 extra starts");

    // Randomised runs: small-magnitude and full-range operands.
    for (int n = 0; n < 6; n++) begin
      randomize_all((n < 3) ? 300 : 0);
      run(1'b0);
    end

    // Mid-run reset aborts, then a fresh run completes normally.
    scen1();
    model();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (120) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_zero("abort");
    dc = done_cnt;
    repeat (300) @(posedge clk);
    #1;
    chk("no done after abort", done_cnt - dc, 0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    run(1'b0);
    check_scen1_literals("scen1 after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
